// File: rtl/neureka_streamer_sequencer.sv
// -----------------------------------------------------------------------------
// neureka_streamer_sequencer
//
// Steps the shared TCDM load/store streamer through up to five phases per job,
// always in the order FEAT, WEIGHT, NORM, STREAMIN, STORE. Only the phases
// enabled in the mask latched at job start are run. For each phase it:
//   - selects the phase on the load mux / load-store select,
//   - pulses the matching source or sink clear,
//   - pulses a start request,
//   - waits for the matching done flag,
//   - waits for the TCDM FIFO to drain.
//
// Optional feature macro: NEUREKA_SEQ_TIMEOUT_EN
//   When defined, a watchdog bounds each WAIT phase to TIMEOUT_CYCLES cycles.
//   On expiry it raises a sticky error_o and forces the phase into DRAIN.
//   When undefined, WAIT has no bound and error_o is tied low.
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   clear_i         synchronous soft clear, same effect as reset
//   start_i         job start pulse, only honoured in IDLE
//   phase_mask_i    {STORE,STREAMIN,NORM,WEIGHT,FEAT} enables, latched at start
//   src_done_i      source done pulse (load phases)
//   sink_done_i     sink done pulse (STORE phase)
//   fifo_empty_i    TCDM FIFO empty flag
//   ld_which_o      load mux select 0=FEAT 1=WEIGHT 2=NORM 3=STREAMIN
//   ld_st_sel_o     1 during the STORE phase
//   clear_source_o  1-cycle pulse on entry to SETUP of a load phase
//   clear_sink_o    1-cycle pulse on entry to SETUP of the STORE phase
//   req_start_o     1-cycle source/sink start request
//   phase_o         current phase index 0..4, 7 when idle
//   busy_o          high from start acceptance until done_o
//   done_o          1-cycle job completion pulse
//   error_o         sticky watchdog error
// -----------------------------------------------------------------------------
module neureka_streamer_sequencer #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic [4:0] phase_mask_i,
    input  logic       src_done_i,
    input  logic       sink_done_i,
    input  logic       fifo_empty_i,
    output logic [1:0] ld_which_o,
    output logic       ld_st_sel_o,
    output logic       clear_source_o,
    output logic       clear_sink_o,
    output logic       req_start_o,
    output logic [2:0] phase_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEXT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_FINISH = 3'd6
    } state_e;

    localparam logic [2:0]  PHASE_STORE = 3'd4;
    localparam logic [2:0]  PHASE_IDLE  = 3'd7;
    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);

    // Index of the lowest set bit; the caller guarantees a non-zero mask.
    function automatic logic [2:0] lowest_phase(input logic [4:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    state_e      state_r;
    logic [4:0]  mask_r;
    logic [15:0] setup_cnt_r;
    logic [1:0]  ld_which_r;
    logic        ld_st_sel_r;
    logic        clear_source_r;
    logic        clear_sink_r;
    logic        req_start_r;
    logic [2:0]  phase_r;
    logic        busy_r;
    logic        done_r;

    logic [2:0]  next_idx_s;
    logic        done_hit_s;

`ifdef NEUREKA_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_r;
    logic        error_r;
`endif

    assign next_idx_s = lowest_phase(mask_r);
    // ld_st_sel_r is stable for the whole phase, so it tells which done flag counts.
    assign done_hit_s = ld_st_sel_r ? sink_done_i : src_done_i;

    // Phase sequencer: state, latched mask, counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_r        <= ST_IDLE;
            mask_r         <= 5'd0;
            setup_cnt_r    <= 16'd0;
            ld_which_r     <= 2'd0;
            ld_st_sel_r    <= 1'b0;
            clear_source_r <= 1'b0;
            clear_sink_r   <= 1'b0;
            req_start_r    <= 1'b0;
            phase_r        <= PHASE_IDLE;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
`ifdef NEUREKA_SEQ_TIMEOUT_EN
            wait_cnt_r     <= 16'd0;
            error_r        <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the state that needs them raises them.
            clear_source_r <= 1'b0;
            clear_sink_r   <= 1'b0;
            req_start_r    <= 1'b0;
            done_r         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        mask_r  <= phase_mask_i;
                        busy_r  <= 1'b1;
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (mask_r == 5'd0) begin
                        // Job complete: busy drops together with the done pulse.
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        phase_r     <= PHASE_IDLE;
                        ld_which_r  <= 2'd0;
                        ld_st_sel_r <= 1'b0;
                        state_r     <= ST_FINISH;
                    end else begin
                        mask_r      <= mask_r & ~(5'b00001 << next_idx_s);
                        phase_r     <= next_idx_s;
                        setup_cnt_r <= SETUP_LAST;
                        if (next_idx_s == PHASE_STORE) begin
                            ld_which_r   <= 2'd0;
                            ld_st_sel_r  <= 1'b1;
                            clear_sink_r <= 1'b1;
                        end else begin
                            ld_which_r     <= next_idx_s[1:0];
                            ld_st_sel_r    <= 1'b0;
                            clear_source_r <= 1'b1;
                        end
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_r == 16'd0) begin
                        req_start_r <= 1'b1;
                        state_r     <= ST_START;
                    end else begin
                        setup_cnt_r <= setup_cnt_r - 16'd1;
                    end
                end
                ST_START: begin
`ifdef NEUREKA_SEQ_TIMEOUT_EN
                    wait_cnt_r <= 16'd0;
`endif
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit_s) begin
                        state_r <= ST_DRAIN;
`ifdef NEUREKA_SEQ_TIMEOUT_EN
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        // Watchdog expiry: flag it and carry on with the job.
                        error_r <= 1'b1;
                        state_r <= ST_DRAIN;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
`else
                    end else begin
                        state_r <= ST_WAIT;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_i) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_which_o     = ld_which_r;
    assign ld_st_sel_o    = ld_st_sel_r;
    assign clear_source_o = clear_source_r;
    assign clear_sink_o   = clear_sink_r;
    assign req_start_o    = req_start_r;
    assign phase_o        = phase_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
`ifdef NEUREKA_SEQ_TIMEOUT_EN
    assign error_o        = error_r;
`else
    assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_neureka_streamer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neureka_streamer_sequencer
//
// Randomised jobs driven against the sequencer. For each job the driver
// derives the phase list from the mask (lowest enabled phase first) and, from
// the moments it applies start/done/FIFO stimulus, the cycle at which the next
// start request or the done pulse must appear. Those expectations go into a
// queue; an independent monitor pops and checks them whenever req_start_o or
// done_o fires.
// -----------------------------------------------------------------------------
module tb_neureka_streamer_sequencer;

    localparam int SETUP = 1;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_ni, clear_i, start_i;
    logic [4:0] phase_mask_i;
    logic       src_done_i, sink_done_i, fifo_empty_i;
    logic [1:0] ld_which_o;
    logic       ld_st_sel_o, clear_source_o, clear_sink_o, req_start_o;
    logic [2:0] phase_o;
    logic       busy_o, done_o, error_o;

    neureka_streamer_sequencer #(
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .phase_mask_i  (phase_mask_i),
        .src_done_i    (src_done_i),
        .sink_done_i   (sink_done_i),
        .fifo_empty_i  (fifo_empty_i),
        .ld_which_o    (ld_which_o),
        .ld_st_sel_o   (ld_st_sel_o),
        .clear_source_o(clear_source_o),
        .clear_sink_o  (clear_sink_o),
        .req_start_o   (req_start_o),
        .phase_o       (phase_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int phase;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_clr_src = 0;
    int   n_clr_snk = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: count clear pulses and check every req_start/done against the queue.
    always @(negedge clk) begin
        if (clear_source_o) n_clr_src++;
        if (clear_sink_o)   n_clr_snk++;
        if (req_start_o || done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_is_done", int'(done_o), int'(mon_e.is_done));
                chk("event_cycle", cyc, mon_e.at);
                chk("event_phase", int'(phase_o), mon_e.phase);
                if (mon_e.is_done) begin
                    chk("busy_at_done", int'(busy_o), 0);
                end else begin
                    chk("busy_at_req", int'(busy_o), 1);
                    chk("ld_st_sel", int'(ld_st_sel_o), (mon_e.phase == 4) ? 1 : 0);
                    if (mon_e.phase < 4) chk("ld_which", int'(ld_which_o), mon_e.phase);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        chk(name, int'({ld_which_o, ld_st_sel_o, clear_source_o, clear_sink_o, req_start_o,
                        phase_o, busy_o, done_o, error_o}), 12'h038);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(done_o), 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done_o), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_phase", int'(phase_o), 7);
    endtask

    // mode 0: normal job, 1: rst_ni in WAIT of 2nd phase, 2: clear_i there.
    // kforce < 0 draws the FIFO-busy length at random.
    task automatic run_job(input logic [4:0] mask, input int mode, input int kforce);
        int plist[$];
        int c0, r, d, k, t, p, nload, nstore;
        bit last;
        plist.delete();
        nload = 0;
        nstore = 0;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                plist.push_back(i);
                if (i == 4) nstore++;
                else nload++;
            end
        end
        @(negedge clk);
        n_clr_src = 0;
        n_clr_snk = 0;
        start_i = 1'b1;
        phase_mask_i = mask;
        c0 = cyc;
        if (plist.size() == 0) exp_q.push_back('{1'b1, 7, c0 + 2});
        else                   exp_q.push_back('{1'b0, plist[0], c0 + 2 + SETUP});
        @(negedge clk);
        start_i = 1'b0;
        phase_mask_i = 5'($urandom);
        for (int pi = 0; pi < plist.size(); pi++) begin
            p = plist[pi];
            last = (pi == plist.size() - 1);
            // Done pulses before WAIT must be ignored.
            t = 0;
            while (!req_start_o && t < 60) begin
                src_done_i  = 1'($urandom);
                sink_done_i = 1'($urandom);
                @(negedge clk);
                t++;
            end
            src_done_i  = 1'b0;
            sink_done_i = 1'b0;
            chk("req_timeout", int'(req_start_o), 1);
            if (!req_start_o) return;
            r = cyc;
            if (mode != 0 && pi == 1) begin
                @(negedge clk);
                if (mode == 1) rst_ni = 1'b0;
                else           clear_i = 1'b1;
                @(negedge clk);
                rst_ni = 1'b1;
                clear_i = 1'b0;
                exp_q.delete();
                check_reset_outputs(mode == 1 ? "abort_rst" : "abort_clear");
                repeat (4) @(negedge clk);
                chk("no_done_after_abort", int'(busy_o), 0);
                return;
            end
            d = $urandom_range(1, 10);
            k = (kforce >= 0) ? kforce : $urandom_range(0, 6);
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                if (p == 4) src_done_i = 1'($urandom);
                else        sink_done_i = 1'($urandom);
                if (j == d - 1) begin
                    if (p == 4) sink_done_i = 1'b1;
                    else        src_done_i = 1'b1;
                    fifo_empty_i = 1'b0;
                end
            end
            c0 = cyc;
            if (last) exp_q.push_back('{1'b1, 7, c0 + k + 3});
            else      exp_q.push_back('{1'b0, plist[pi + 1], c0 + k + 3 + SETUP});
            @(negedge clk);
            src_done_i  = 1'b0;
            sink_done_i = 1'b0;
            repeat (k) @(negedge clk);
            fifo_empty_i = 1'b1;
            if (r < 0) return;
        end
        wait_done("done_timeout");
        chk("clear_source_count", n_clr_src, nload);
        chk("clear_sink_count", n_clr_snk, nstore);
`ifndef NEUREKA_SEQ_TIMEOUT_EN
        chk("error_tied_low", int'(error_o), 0);
`endif
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b0;
        phase_mask_i = 5'd0;
        src_done_i = 1'b0;
        sink_done_i = 1'b0;
        fifo_empty_i = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_ni = 1'b1;
        @(negedge clk);

        run_job(5'b00001, 0, -1);   // single FEAT phase
        run_job(5'b10011, 0, -1);   // FEAT, WEIGHT, STORE
        run_job(5'b00000, 0, -1);   // empty mask
        run_job(5'b00001, 0, 7);    // long drain
        run_job(5'b00011, 1, -1);   // reset mid-job
        run_job(5'b00101, 0, -1);   // fresh start after reset
        run_job(5'b11000, 2, -1);   // soft clear mid-job
        run_job(5'b11111, 0, -1);
        for (int n = 0; n < 25; n++) begin
            run_job(5'($urandom), 0, -1);
        end

`ifdef NEUREKA_SEQ_TIMEOUT_EN
        begin
            int r, t;
            @(negedge clk);
            start_i = 1'b1;
            phase_mask_i = 5'b00001;
            exp_q.push_back('{1'b0, 0, cyc + 2 + SETUP});
            @(negedge clk);
            start_i = 1'b0;
            t = 0;
            while (!req_start_o && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("tmo_req_timeout", int'(req_start_o), 1);
            r = cyc;
            exp_q.push_back('{1'b1, 7, r + TMO + 3});
            t = 0;
            while (!error_o && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("tmo_error_rise", int'(error_o), 1);
            chk("tmo_error_cycle", cyc, r + TMO + 1);
            wait_done("tmo_done_timeout");
            chk("tmo_error_sticky", int'(error_o), 1);
            clear_i = 1'b1;
            @(negedge clk);
            clear_i = 1'b0;
            chk("tmo_error_cleared", int'(error_o), 0);
        end
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
